// File: rtl/match_scheduler.sv
// Time-shares one external 32-bit equality comparator across NUM_KEYS stored keys, one key per cycle.
// Result after NUM_KEYS cycles; define MATCH_EARLY_EXIT_EN to finish at the first qualified hit.
module match_scheduler #(
   parameter int NUM_KEYS = 4,
   parameter int IDX_W    = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key_wr_en,
   input  logic [IDX_W-1:0] key_wr_idx,
   input  logic [31:0]      key_wr_data,
   input  logic             key_clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_hit,
   output logic [IDX_W-1:0] out_idx,
   output logic [31:0]      cmp_a,
   output logic [31:0]      cmp_b,
   input  logic             cmp_eq
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t              state, state_nxt;
   logic [31:0]         word;
   logic [31:0]         keys [NUM_KEYS];
   logic [NUM_KEYS-1:0] valid;
   logic [IDX_W-1:0]    idx;
   logic [IDX_W-1:0]    hit_idx;
   logic                hit;
   logic                last;
   logic                qmatch;
   logic                accept;

   assign last   = (idx == IDX_W'(NUM_KEYS - 1));
   assign qmatch = (state == SCAN) & cmp_eq & valid[idx];
   assign accept = in_valid & in_ready;

   // Operands come straight from registers so cmp_eq never feeds back into them.
   assign cmp_a = (state == SCAN) ? word : 32'd0;
   assign cmp_b = (state == SCAN) ? keys[idx] : 32'd0;

   assign out_hit = (state == DONE) & hit;
   assign out_idx = (state == DONE) ? hit_idx : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = SCAN;
         end
         SCAN: begin
`ifdef MATCH_EARLY_EXIT_EN
            if (qmatch || last) state_nxt = DONE;
`else
            if (last) state_nxt = DONE;
`endif
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word    <= '0;
         valid   <= '0;
         idx     <= '0;
         hit     <= 1'b0;
         hit_idx <= '0;
         for (int k = 0; k < NUM_KEYS; k++) keys[k] <= '0;
      end else begin
         // Clear first so a same-cycle write re-validates its own index.
         if (key_clr) valid <= '0;
         for (int k = 0; k < NUM_KEYS; k++) begin
            if (key_wr_en && key_wr_idx == IDX_W'(k)) begin
               keys[k]  <= key_wr_data;
               valid[k] <= 1'b1;
            end
         end

         if (accept) begin
            word    <= in_data;
            idx     <= '0;
            hit     <= 1'b0;
            hit_idx <= '0;
         end else if (state == SCAN) begin
            if (qmatch && !hit) begin
               hit     <= 1'b1;
               hit_idx <= idx;
            end
            if (!last) idx <= idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_match_scheduler.sv
// Directed bench for match_scheduler with a behavioural equality comparator on the cmp_* ports.
module tb_match_scheduler;
   localparam int NK = 4;
   localparam int IW = 2;
`ifdef MATCH_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          key_wr_en;
   logic [IW-1:0] key_wr_idx;
   logic [31:0]   key_wr_data;
   logic          key_clr;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_hit;
   logic [IW-1:0] out_idx;
   logic [31:0]   cmp_a;
   logic [31:0]   cmp_b;
   logic          cmp_eq;

   int checks = 0;
   int errors = 0;

   match_scheduler #(.NUM_KEYS(NK), .IDX_W(IW)) dut (
      .clk(clk), .rst_n(rst_n),
      .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data), .key_clr(key_clr),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit), .out_idx(out_idx),
      .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_eq(cmp_eq)
   );

   assign cmp_eq = (cmp_a == cmp_b);

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic write_key(input logic [IW-1:0] i, input logic [31:0] d, input logic clr);
      key_wr_en   = 1'b1;
      key_wr_idx  = i;
      key_wr_data = d;
      key_clr     = clr;
      step();
      key_wr_en = 1'b0;
      key_clr   = 1'b0;
   endtask

   task automatic offer(input string tag, input logic [31:0] d);
      in_data  = d;
      in_valid = 1'b1;
      check({tag, "_rdy_before"}, in_ready, 1);
      step();
      in_valid = 1'b0;
      check({tag, "_rdy_after"}, in_ready, 0);
      check({tag, "_cmp_a"}, cmp_a, d);
   endtask

   function automatic int lat_hit(input int k);
      return EARLY ? k + 1 : NK;
   endfunction

   task automatic wait_result(input string tag, input logic eh, input logic [IW-1:0] ei, input int el);
      int n = 0;
      while (!out_valid && n < 40) begin
         step();
         n++;
      end
      check({tag, "_latency"}, n, el);
      check({tag, "_hit"}, out_hit, eh);
      check({tag, "_idx"}, out_idx, ei);
      if (out_ready) begin
         step();
         check({tag, "_vld_drop"}, out_valid, 0);
         check({tag, "_rdy_back"}, in_ready, 1);
      end
   endtask

   initial begin
      rst_n = 1'b0; key_wr_en = 1'b0; key_wr_idx = '0; key_wr_data = '0; key_clr = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

      // 1: reset state, then word 0 must miss against all-invalid zero keys
      repeat (3) step();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_hit", out_hit, 0);
      check("rst_out_idx", out_idx, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_cmp_a", cmp_a, 0);
      check("rst_cmp_b", cmp_b, 0);
      rst_n = 1'b1;
      step();
      offer("zero", 32'h0000_0000);
      wait_result("zero", 1'b0, 2'd0, NK);

      // 2: hit at index 2
      write_key(2'd0, 32'hFF00_FF00, 1'b0);
      write_key(2'd1, 32'h1108_F302, 1'b0);
      write_key(2'd2, 32'hFF28_FF00, 1'b0);
      write_key(2'd3, 32'hFF28_F1F0, 1'b0);
      offer("hit2", 32'hFF28_FF00);
      check("hit2_cmp_b_key0", cmp_b, 32'hFF00_FF00);
      wait_result("hit2", 1'b1, 2'd2, lat_hit(2));

      // 3: miss
      offer("miss", 32'h1234_5678);
      wait_result("miss", 1'b0, 2'd0, NK);

      // 4: duplicates report the lowest index; clear invalidates everything
      write_key(2'd1, 32'hAAAA_5555, 1'b0);
      write_key(2'd3, 32'hAAAA_5555, 1'b0);
      offer("dup", 32'hAAAA_5555);
      wait_result("dup", 1'b1, 2'd1, lat_hit(1));
      key_clr = 1'b1;
      step();
      key_clr = 1'b0;
      offer("clr", 32'hAAAA_5555);
      wait_result("clr", 1'b0, 2'd0, NK);

      // same-cycle clear and write: only the written index survives
      write_key(2'd2, 32'h0BAD_F00D, 1'b1);
      offer("clrwr_hit", 32'h0BAD_F00D);
      wait_result("clrwr_hit", 1'b1, 2'd2, lat_hit(2));
      offer("clrwr_k0", 32'hFF00_FF00);
      wait_result("clrwr_k0", 1'b0, 2'd0, NK);

      // 5: backpressure in DONE, second word waiting on in_valid
      out_ready = 1'b0;
      offer("bp", 32'h0BAD_F00D);
      wait_result("bp", 1'b1, 2'd2, lat_hit(2));
      for (int c = 0; c < 5; c++) begin
         step();
         check("bp_hold_vld", out_valid, 1);
         check("bp_hold_hit", out_hit, 1);
         check("bp_hold_idx", out_idx, 2);
         check("bp_hold_rdy", in_ready, 0);
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'h1234_5678;
      step();
      check("bp_release_vld", out_valid, 0);
      check("bp_release_rdy", in_ready, 1);
      step();
      in_valid = 1'b0;
      check("bp_second_taken", in_ready, 0);
      check("bp_second_cmp_a", cmp_a, 32'h1234_5678);
      wait_result("bp_second", 1'b0, 2'd0, NK);

      // 6: reset at T0+2 aborts the scan and invalidates keys
      offer("abort", 32'h0BAD_F00D);
      step();
      step();
      rst_n = 1'b0;
      #1;
      check("abort_rst_vld", out_valid, 0);
      check("abort_rst_rdy", in_ready, 1);
      check("abort_rst_cmp_a", cmp_a, 0);
      step();
      step();
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         step();
         check("abort_no_result", out_valid, 0);
      end
      check("abort_rdy_after", in_ready, 1);
      offer("abort_keys", 32'h0BAD_F00D);
      wait_result("abort_keys", 1'b0, 2'd0, NK);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/match_scheduler.md
# match_scheduler

Sequencer that shares one external 32-bit equality comparator across a small table of stored keys. Accepts a data word over a valid/ready handshake, steps the comparator through every valid key one per cycle, and returns hit/miss plus the matching key index. Sits between a packet-field extractor and downstream filter logic. The `equality_32` instance lives outside and connects through the `cmp_*` ports.

## Interface
- `NUM_KEYS`, default 4: number of key registers; legal range is 2..16.
- `IDX_W`, default 2: index width; must equal ceil(log2(`NUM_KEYS`)).

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_wr_en`  in  1  writes `key_wr_data` to key[`key_wr_idx`] and sets that key's valid bit.
- `key_wr_idx`  in  `IDX_W`  key write index.
- `key_wr_data`  in  32  key value.
- `key_clr`  in  1  clears all key valid bits.
- `in_valid`  in  1  input word is offered.
- `in_ready`  out  1  block can accept a word.
- `in_data`  in  32  word to match.
- `out_valid`  out  1  result is available.
- `out_ready`  in  1  consumer accepts the result.
- `out_hit`  out  1  at least one valid key matched.
- `out_idx`  out  `IDX_W`  lowest matching index; 0 on a miss.
- `cmp_a`, `cmp_b`  out  32  comparator operands.
- `cmp_eq`  in  1  comparator result (combinational from `cmp_a`/`cmp_b`).

## Operation
- Reset state: FSM in IDLE; all keys 0; all valid bits 0; `out_valid`=0, `out_hit`=0, `out_idx`=0, `in_ready`=1, `cmp_a`=`cmp_b`=0.
- FSM has three states: IDLE, SCAN, DONE.
- IDLE
  - `in_ready`=1.
  - On `in_valid`, latch `in_data` into the word register, set scan index to 0, clear the hit flag, go to SCAN.
- SCAN
  - `cmp_a` = word register; `cmp_b` = key[idx].
  - A qualified match is `cmp_eq & valid[idx]`.
  - On the first qualified match, set hit and record `hit_idx`=idx. Later matches never overwrite it.
  - When idx = `NUM_KEYS`-1, go to DONE; otherwise increment idx.
- DONE
  - `out_valid`=1; `out_hit` and `out_idx` stay stable.
  - On `out_ready`, return to IDLE.
- `cmp_a`/`cmp_b` are driven 0 outside SCAN.
- Key writes are accepted in any state and take effect the next cycle. A SCAN compare uses the register value present in that cycle.
- If `key_clr` and `key_wr_en` are asserted in the same cycle: all valid bits clear, then the written index is set valid (the write wins for its index).
- Invalid keys never match, including key value 0 against word 0.
- Deasserting `rst_n` mid-scan or in DONE aborts the operation: the word is dropped, no result is produced, and all registers return to reset values.

## Timing
- Let T0 be the edge where `in_valid & in_ready` is accepted.
- Key k is compared in the cycle after edge T0+k.
- Full scan: DONE is entered and `out_valid` rises at edge T0+`NUM_KEYS`.
- `in_ready` is low from T0 until the edge after `out_valid & out_ready`. The next word can be accepted at the earliest one cycle after the result handshake.
- Minimum initiation interval is `NUM_KEYS`+2 cycles.
- No combinational path exists from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`.

## Configuration
- `MATCH_EARLY_EXIT_EN`
  - Defined: SCAN goes to DONE at the first qualified match. A hit at index k raises `out_valid` at edge T0+k+1; misses still take `NUM_KEYS` cycles.
  - Undefined: every scan runs all `NUM_KEYS` keys regardless of hits. Latency is constant at `NUM_KEYS`.
  - The reported `out_hit`/`out_idx` are identical in both builds.

## Test plan
1. Reset behaviour: hold `rst_n` low 3 cycles -> `out_valid`=0, `out_hit`=0, `out_idx`=0, `in_ready`=1. Then offer word 0x00000000 -> miss, because no key is valid.
2. Hit: program keys {0:0xFF00FF00, 1:0x1108F302, 2:0xFF28FF00, 3:0xFF28F1F0}, offer 0xFF28FF00 -> `out_hit`=1, `out_idx`=2. `out_valid` rises at T0+4 without the macro, T0+3 with it.
3. Miss: same keys, offer 0x12345678 -> `out_hit`=0, `out_idx`=0, `out_valid` at T0+4 in both builds.
4. Duplicate keys and clear: set key1 = key3 = 0xAAAA5555, offer 0xAAAA5555 -> `out_idx`=1. Then pulse `key_clr` and offer 0xAAAA5555 again -> miss.
5. Backpressure: hold `out_ready` low for 5 cycles in DONE -> `out_valid`, `out_hit` and `out_idx` are stable and `in_ready`=0. Raise `out_ready` with a second word already on `in_valid` -> the second word is accepted on the following edge.
6. Reset mid-scan: drop `rst_n` at T0+2 -> no `out_valid` appears, all keys are invalid, and `in_ready`=1 after reset is released.
